// File: rtl/ltpi_data_channel_arbiter.sv
// Round-robin arbiter sharing one LTPI data channel between NUM_REQ controllers; 1-cycle grant latency,
// request held until dn_req_ack, completions routed back by tag in one registered cycle.
package ltpi_dc_pkg;

  localparam logic [3:0] READ_REQ   = 4'h0;
  localparam logic [3:0] WRITE_REQ  = 4'h1;
  localparam logic [3:0] READ_COMP  = 4'h2;
  localparam logic [3:0] WRITE_COMP = 4'h3;
  localparam logic [3:0] CRC_ERROR  = 4'h4;

  typedef struct packed {
    logic [3:0]  command;
    logic [7:0]  tag;
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  byte_en;
    logic [7:0]  status;
  } Data_channel_payload_t;

endpackage

module ltpi_data_channel_arbiter
  import ltpi_dc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    up_req_valid,
  input  Data_channel_payload_t up_req [NUM_REQ],
  output logic [NUM_REQ-1:0]    up_req_ack,
  input  logic [NUM_REQ-1:0]    up_abort,
  output logic [NUM_REQ-1:0]    up_resp_valid,
  output Data_channel_payload_t up_resp,
  output logic                  dn_req_valid,
  input  logic                  dn_req_ack,
  output Data_channel_payload_t dn_req,
  input  logic                  dn_resp_valid,
  input  Data_channel_payload_t dn_resp,
  output logic [NUM_REQ-1:0]    outstanding,
  output logic [7:0]            stray_resp_cnt
);

  localparam int SEQ_W = 8 - IDX_W;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_FWD  = 1'b1;

  logic [0:0]         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win;
  logic               fwd_abort;
  logic [SEQ_W-1:0]   seq [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [SEQ_W-1:0]   pick_seq;
  int                 cand;
  logic [NUM_REQ-1:0] win_oh;
  logic               accept;
  logic               grant_kept;

  logic [IDX_W-1:0]   resp_idx;
  logic [NUM_REQ-1:0] idx_oh;
  logic               is_comp;
  logic               is_crc;
  logic [NUM_REQ-1:0] resp_oh;
  logic               stray;
  logic [NUM_REQ-1:0] out_nxt;

  // First eligible requester strictly after the round-robin pointer, wrapping.
  always_comb begin
    elig     = up_req_valid & ~outstanding & ~up_abort;
    found    = 1'b0;
    pick     = rr_ptr;
    pick_seq = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) pick_seq = seq[i];
    end
  end

  always_comb begin
    win_oh     = NUM_REQ'(1) << win;
    accept     = (state == ARB_FWD) && dn_req_ack;
    grant_kept = !(fwd_abort || |(up_abort & win_oh));
  end

  // Response decode; an abort in the same cycle swallows the response silently.
  always_comb begin
    resp_idx = dn_resp.tag[7:8-IDX_W];
    idx_oh   = (int'(resp_idx) < NUM_REQ) ? (NUM_REQ'(1) << resp_idx) : '0;
    is_comp  = (dn_resp.command == READ_COMP) || (dn_resp.command == WRITE_COMP);
    is_crc   = (dn_resp.command == CRC_ERROR);
    resp_oh  = '0;
    stray    = 1'b0;
    if (dn_resp_valid) begin
      if (is_comp) begin
        resp_oh = idx_oh & outstanding & ~up_abort;
        stray   = ~|(idx_oh & outstanding);
      end else if (is_crc) begin
        resp_oh = outstanding & ~up_abort;
        stray   = ~|outstanding;
      end else begin
        stray   = 1'b1;
      end
    end
  end

  always_comb begin
    out_nxt = outstanding & ~resp_oh & ~up_abort;
    if (accept && grant_kept) out_nxt = out_nxt | win_oh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ARB_IDLE;
      rr_ptr         <= IDX_W'(NUM_REQ - 1);
      win            <= '0;
      fwd_abort      <= 1'b0;
      dn_req_valid   <= 1'b0;
      dn_req         <= '0;
      up_req_ack     <= '0;
      up_resp_valid  <= '0;
      up_resp        <= '0;
      outstanding    <= '0;
      stray_resp_cnt <= '0;
      for (int i = 0; i < NUM_REQ; i++) seq[i] <= '0;
    end else begin
      up_req_ack    <= '0;
      up_resp_valid <= resp_oh;
      outstanding   <= out_nxt;

      if (|resp_oh) up_resp <= dn_resp;
      if (stray && stray_resp_cnt != 8'hFF) stray_resp_cnt <= stray_resp_cnt + 8'd1;

      case (state)
        ARB_IDLE: begin
          if (found) begin
            for (int i = 0; i < NUM_REQ; i++) begin
              if (pick == IDX_W'(i)) dn_req <= up_req[i];
            end
            dn_req.tag   <= {pick, pick_seq};
            dn_req_valid <= 1'b1;
            win          <= pick;
            fwd_abort    <= 1'b0;
            state        <= ARB_FWD;
          end
        end
        ARB_FWD: begin
          fwd_abort <= fwd_abort | |(up_abort & win_oh);
          if (dn_req_ack) begin
            dn_req_valid <= 1'b0;
            up_req_ack   <= win_oh;
            rr_ptr       <= win;
            state        <= ARB_IDLE;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (win_oh[i]) seq[i] <= seq[i] + SEQ_W'(1);
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltpi_data_channel_arbiter.sv
// Directed bench for ltpi_data_channel_arbiter: grants, fairness, routing, CRC broadcast, strays, aborts, reset.
module tb_ltpi_data_channel_arbiter;
  import ltpi_dc_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [3:0]            up_req_valid;
  Data_channel_payload_t up_req [4];
  logic [3:0]            up_req_ack;
  logic [3:0]            up_abort;
  logic [3:0]            up_resp_valid;
  Data_channel_payload_t up_resp;
  logic                  dn_req_valid;
  logic                  dn_req_ack;
  Data_channel_payload_t dn_req;
  logic                  dn_resp_valid;
  Data_channel_payload_t dn_resp;
  logic [3:0]            outstanding;
  logic [7:0]            stray_resp_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ltpi_data_channel_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .up_req_valid   (up_req_valid),
    .up_req         (up_req),
    .up_req_ack     (up_req_ack),
    .up_abort       (up_abort),
    .up_resp_valid  (up_resp_valid),
    .up_resp        (up_resp),
    .dn_req_valid   (dn_req_valid),
    .dn_req_ack     (dn_req_ack),
    .dn_req         (dn_req),
    .dn_resp_valid  (dn_resp_valid),
    .dn_resp        (dn_resp),
    .outstanding    (outstanding),
    .stray_resp_cnt (stray_resp_cnt)
  );

  function automatic Data_channel_payload_t mk(input logic [3:0] cmd, input logic [7:0] tag,
                                               input logic [31:0] addr);
    Data_channel_payload_t p;
    p         = '0;
    p.command = cmd;
    p.tag     = tag;
    p.address = addr;
    p.data    = addr ^ 32'hA5A5_0000;
    p.byte_en = 4'hF;
    return p;
  endfunction

  task automatic do_reset();
    reset         = 1'b1;
    up_req_valid  = '0;
    up_abort      = '0;
    dn_req_ack    = 1'b0;
    dn_resp_valid = 1'b0;
    dn_resp       = '0;
    for (int i = 0; i < 4; i++) up_req[i] = mk(READ_REQ, 8'h3F, 32'h100 * i);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_dn_valid(input string name);
    for (int k = 0; k < 20 && !dn_req_valid; k++) @(negedge clk);
    if (!dn_req_valid) begin
      checks++; failures++;
      $display("FAIL %s timeout waiting dn_req_valid got=%0b want=1", name, dn_req_valid);
    end
  endtask

  task automatic send_resp(input logic [3:0] cmd, input logic [7:0] tag);
    dn_resp       = mk(cmd, tag, 32'hBEEF);
    dn_resp_valid = 1'b1;
    @(negedge clk);
    dn_resp_valid = 1'b0;
  endtask

  // Stimulus only: issues one request from requester i and returns the tag seen downstream.
  task automatic issue(input int i, output logic [7:0] tag);
    up_req_valid[i] = 1'b1;
    wait_dn_valid("issue");
    tag        = dn_req.tag;
    dn_req_ack = 1'b1;
    @(negedge clk);
    dn_req_ack      = 1'b0;
    up_req_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({dn_req_valid, up_req_ack, up_resp_valid, outstanding, stray_resp_cnt} !== 21'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%h want=0",
               {dn_req_valid, up_req_ack, up_resp_valid, outstanding, stray_resp_cnt});
    end
    checks++;
    if (dn_req !== '0 || up_resp !== '0 || dn_req.command !== READ_REQ) begin
      failures++;
      $display("FAIL reset_payload got dn=%h up=%h want=0", dn_req, up_resp);
    end
  endtask

  task automatic test_single();
    do_reset();
    up_req[1]       = mk(WRITE_REQ, 8'h55, 32'h10);
    up_req_valid[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (dn_req_valid !== 1'b1 || dn_req.tag !== 8'h40 || dn_req.command !== WRITE_REQ ||
        dn_req.address !== 32'h10) begin
      failures++;
      $display("FAIL single_issue got vld=%0b tag=%h cmd=%h addr=%h want vld=1 tag=40 cmd=1 addr=10",
               dn_req_valid, dn_req.tag, dn_req.command, dn_req.address);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (dn_req_valid !== 1'b1 || dn_req.tag !== 8'h40 || up_req_ack !== 4'b0000) begin
        failures++;
        $display("FAIL single_hold got vld=%0b tag=%h ack=%b want vld=1 tag=40 ack=0000",
                 dn_req_valid, dn_req.tag, up_req_ack);
      end
    end
    dn_req_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (up_req_ack !== 4'b0010 || dn_req_valid !== 1'b0 || outstanding !== 4'b0010) begin
      failures++;
      $display("FAIL single_ack got ack=%b vld=%0b out=%b want ack=0010 vld=0 out=0010",
               up_req_ack, dn_req_valid, outstanding);
    end
    dn_req_ack      = 1'b0;
    up_req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (up_req_ack !== 4'b0000 || dn_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_ack_pulse got ack=%b vld=%0b want ack=0000 vld=0", up_req_ack, dn_req_valid);
    end
    send_resp(WRITE_COMP, 8'h40);
    checks++;
    if (up_resp_valid !== 4'b0010 || outstanding !== 4'b0000 || up_resp.tag !== 8'h40 ||
        up_resp.command !== WRITE_COMP) begin
      failures++;
      $display("FAIL single_resp got rv=%b out=%b tag=%h cmd=%h want rv=0010 out=0000 tag=40 cmd=3",
               up_resp_valid, outstanding, up_resp.tag, up_resp.command);
    end
    @(negedge clk);
    checks++;
    if (up_resp_valid !== 4'b0000) begin
      failures++;
      $display("FAIL single_resp_pulse got rv=%b want=0000", up_resp_valid);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_tag [5];
    logic [7:0] t;
    exp_tag = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h01};
    do_reset();
    up_req_valid = 4'b1111;
    dn_req_ack   = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_dn_valid("fair");
      t = dn_req.tag;
      checks++;
      if (t !== exp_tag[n]) begin
        failures++;
        $display("FAIL fair_tag[%0d] got=%h want=%h", n, t, exp_tag[n]);
      end
      @(negedge clk);
      checks++;
      if (up_req_ack !== (4'b0001 << (n % 4))) begin
        failures++;
        $display("FAIL fair_ack[%0d] got=%b want=%b", n, up_req_ack, 4'b0001 << (n % 4));
      end
      if (n == 4) begin
        up_req_valid = '0;
        dn_req_ack   = 1'b0;
      end
      send_resp(WRITE_COMP, t);
    end
    checks++;
    if (outstanding !== 4'b0000 || dn_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL fair_drain got out=%b vld=%0b want out=0000 vld=0", outstanding, dn_req_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] t;
    do_reset();
    issue(1, t);
    up_req_valid[2] = 1'b1;
    wait_dn_valid("b2b");
    dn_req_ack = 1'b1;
    send_resp(WRITE_COMP, 8'h40);
    checks++;
    if (up_req_ack !== 4'b0100 || up_resp_valid !== 4'b0010 || outstanding !== 4'b0100) begin
      failures++;
      $display("FAIL b2b_ack_and_resp got ack=%b rv=%b out=%b want ack=0100 rv=0010 out=0100",
               up_req_ack, up_resp_valid, outstanding);
    end
    dn_req_ack      = 1'b0;
    up_req_valid[2] = 1'b0;
    send_resp(READ_COMP, 8'h80);
  endtask

  task automatic test_crc_broadcast();
    logic [7:0] t;
    do_reset();
    issue(0, t);
    issue(2, t);
    checks++;
    if (outstanding !== 4'b0101) begin
      failures++;
      $display("FAIL crc_setup got out=%b want=0101", outstanding);
    end
    send_resp(CRC_ERROR, 8'h3F);
    checks++;
    if (up_resp_valid !== 4'b0101 || outstanding !== 4'b0000 || stray_resp_cnt !== 8'd0 ||
        up_resp.command !== CRC_ERROR) begin
      failures++;
      $display("FAIL crc_bcast got rv=%b out=%b stray=%0d cmd=%h want rv=0101 out=0000 stray=0 cmd=4",
               up_resp_valid, outstanding, stray_resp_cnt, up_resp.command);
    end
    send_resp(CRC_ERROR, 8'h3F);
    checks++;
    if (up_resp_valid !== 4'b0000 || stray_resp_cnt !== 8'd1) begin
      failures++;
      $display("FAIL crc_idle got rv=%b stray=%0d want rv=0000 stray=1", up_resp_valid, stray_resp_cnt);
    end
  endtask

  task automatic test_stray();
    int routed;
    routed = 0;
    do_reset();
    dn_resp       = mk(READ_COMP, 8'h80, 32'h0);
    dn_resp_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (up_resp_valid !== 4'b0000) routed++;
      if (i == 9) begin
        checks++;
        if (stray_resp_cnt !== 8'd10) begin
          failures++;
          $display("FAIL stray_count10 got=%0d want=10", stray_resp_cnt);
        end
      end
    end
    dn_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (stray_resp_cnt !== 8'd255 || routed != 0) begin
      failures++;
      $display("FAIL stray_saturate got cnt=%0d routed=%0d want cnt=255 routed=0", stray_resp_cnt, routed);
    end
  endtask

  task automatic test_abort();
    logic [7:0] t;
    do_reset();
    issue(3, t);
    checks++;
    if (t !== 8'hC0 || outstanding !== 4'b1000) begin
      failures++;
      $display("FAIL abort_setup got tag=%h out=%b want tag=c0 out=1000", t, outstanding);
    end
    up_abort[3] = 1'b1;
    @(negedge clk);
    up_abort[3] = 1'b0;
    checks++;
    if (outstanding !== 4'b0000) begin
      failures++;
      $display("FAIL abort_clear got out=%b want=0000", outstanding);
    end
    send_resp(READ_COMP, 8'hC0);
    checks++;
    if (up_resp_valid !== 4'b0000 || stray_resp_cnt !== 8'd1) begin
      failures++;
      $display("FAIL abort_late_resp got rv=%b stray=%0d want rv=0000 stray=1", up_resp_valid, stray_resp_cnt);
    end
    issue(3, t);
    up_abort[3] = 1'b1;
    send_resp(READ_COMP, 8'hC1);
    up_abort[3] = 1'b0;
    checks++;
    if (t !== 8'hC1 || up_resp_valid !== 4'b0000 || stray_resp_cnt !== 8'd1 || outstanding !== 4'b0000) begin
      failures++;
      $display("FAIL abort_same_cycle got tag=%h rv=%b stray=%0d out=%b want tag=c1 rv=0000 stray=1 out=0000",
               t, up_resp_valid, stray_resp_cnt, outstanding);
    end
    up_req_valid[2] = 1'b1;
    wait_dn_valid("abort_fwd");
    up_abort[2] = 1'b1;
    @(negedge clk);
    up_abort[2] = 1'b0;
    dn_req_ack  = 1'b1;
    @(negedge clk);
    checks++;
    if (up_req_ack !== 4'b0100 || outstanding !== 4'b0000 || dn_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_fwd got ack=%b out=%b vld=%0b want ack=0100 out=0000 vld=0",
               up_req_ack, outstanding, dn_req_valid);
    end
    dn_req_ack      = 1'b0;
    up_req_valid[2] = 1'b0;
  endtask

  task automatic test_reset_mid_transfer();
    logic [7:0] t;
    do_reset();
    issue(1, t);
    up_req_valid[2] = 1'b1;
    wait_dn_valid("rst_mid");
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dn_req_valid !== 1'b0 || outstanding !== 4'b0000 || up_req_ack !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid_clear got vld=%0b out=%b ack=%b want vld=0 out=0000 ack=0000",
               dn_req_valid, outstanding, up_req_ack);
    end
    reset        = 1'b0;
    up_req_valid = 4'b1111;
    wait_dn_valid("rst_mid_regrant");
    checks++;
    if (dn_req.tag !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_first_winner got tag=%h want=00", dn_req.tag);
    end
    up_req_valid = '0;
    send_resp(WRITE_COMP, 8'h40);
    checks++;
    if (up_resp_valid !== 4'b0000 || stray_resp_cnt !== 8'd1) begin
      failures++;
      $display("FAIL rst_mid_late_resp got rv=%b stray=%0d want rv=0000 stray=1", up_resp_valid, stray_resp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_crc_broadcast();
    test_stray();
    test_abort();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
